// File: rtl/intr_timer_ctrl.sv
// intr_timer_ctrl: machine-level interrupt controller and timer for the RV32 core.
// Arbitrates a prescaled mtime/mtimecmp timer (ID 0) and NUM_IRQ external lines
// (ID k = irq_in[k-1]) and presents one request at a time to the trap logic.
// No nesting: a taken interrupt is tracked until mret.
// Optional build macro INTR_VECTOR_EN adds the mtvec_base register (addr 5) and intr_pc.
//
//   state   | meaning
//   IDLE    | no request outstanding, waiting for an enabled pending source
//   REQ     | intr_req high, intr_id frozen, waiting for ack (or mie drop)
//   SERVICE | trap taken, intr_id is the in-service ID, waiting for mret
module intr_timer_ctrl #(
    parameter int NUM_IRQ = 8,
    parameter int TIMER_W = 32,
    parameter int PRESC_W = 8,
    parameter int ID_W    = $clog2(NUM_IRQ + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mie,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    input  logic               intr_ack,
    input  logic               is_mret,
    output logic               intr_req,
    output logic [ID_W-1:0]    intr_id,
    output logic               t_intr,
    output logic               e_intr,
    output logic [TIMER_W-1:0] mtime
`ifdef INTR_VECTOR_EN
    ,
    output logic [31:0]        intr_pc
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t             state;
    logic [NUM_IRQ-1:0] irq_en;
    logic [NUM_IRQ-1:0] irq_edge;
    logic [TIMER_W-1:0] mtimecmp;
    logic [PRESC_W-1:0] prescale;
    logic [PRESC_W-1:0] presc_cnt;
    logic [NUM_IRQ-1:0] sync1, sync2, sync3;
    logic [NUM_IRQ-1:0] pend_edge;
    logic [NUM_IRQ-1:0] edge_rise;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] active;
    logic [ID_W-1:0]    win_id;
    logic               take_ack;
    logic               mtime_wr;
`ifdef INTR_VECTOR_EN
    logic [31:0]        mtvec_base;
`endif

    assign take_ack = (state == REQ) && intr_ack;
    assign mtime_wr = cfg_we && (cfg_addr == 3'd4);

    // Configuration register writes (mtime is handled with the timer below)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en   <= '0;
            irq_edge <= '0;
            mtimecmp <= '1;
            prescale <= '0;
        end else if (cfg_we) begin
            case (cfg_addr)
                3'd0:    irq_en   <= cfg_wdata[NUM_IRQ-1:0];
                3'd1:    irq_edge <= cfg_wdata[NUM_IRQ-1:0];
                3'd2:    mtimecmp <= TIMER_W'(cfg_wdata);
                3'd3:    prescale <= PRESC_W'(cfg_wdata);
                default: ;
            endcase
        end
    end

`ifdef INTR_VECTOR_EN
    // Vector base is word aligned; the low two bits are never stored
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mtvec_base <= '0;
        else if (cfg_we && (cfg_addr == 3'd5))
            mtvec_base <= {cfg_wdata[31:2], 2'b00};
    end

    assign intr_pc = intr_req ? (mtvec_base + (32'(intr_id) << 2)) : 32'd0;
`endif

    // Combinational read mux; unimplemented addresses read zero
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            3'd0:    cfg_rdata = 32'(irq_en);
            3'd1:    cfg_rdata = 32'(irq_edge);
            3'd2:    cfg_rdata = 32'(mtimecmp);
            3'd3:    cfg_rdata = 32'(prescale);
            3'd4:    cfg_rdata = 32'(mtime);
`ifdef INTR_VECTOR_EN
            3'd5:    cfg_rdata = mtvec_base;
`endif
            default: cfg_rdata = '0;
        endcase
    end

    // Prescaled timer; a software load wins over the tick and restarts the prescaler
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime     <= '0;
            presc_cnt <= '0;
        end else if (mtime_wr) begin
            mtime     <= TIMER_W'(cfg_wdata);
            presc_cnt <= '0;
        end else if (presc_cnt == prescale) begin
            mtime     <= mtime + 1'b1;
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    assign t_intr = (mtime >= mtimecmp);

    // Two-flop synchroniser plus a third stage used only for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign edge_rise = sync2 & ~sync3 & irq_edge;

    // Ack clears only the pending bit of the ID currently being requested
    always_comb begin
        ack_clr = '0;
        for (int k = 0; k < NUM_IRQ; k++)
            ack_clr[k] = take_ack && (intr_id == ID_W'(k + 1));
    end

    // Latched edge pending; a new edge in the ack cycle survives the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pend_edge <= '0;
        else
            pend_edge <= (pend_edge & ~ack_clr) | edge_rise;
    end

    assign pending = (irq_edge & pend_edge) | (~irq_edge & sync2);
    assign active  = pending & irq_en;
    assign e_intr  = |active;

    // Fixed priority: timer first, then lowest irq index
    always_comb begin
        win_id = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--)
            if (active[k])
                win_id = ID_W'(k + 1);
        if (t_intr)
            win_id = '0;
    end

    // Request/service sequencing with registered request and ID
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            intr_req <= 1'b0;
            intr_id  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mie && (t_intr || e_intr)) begin
                        state    <= REQ;
                        intr_req <= 1'b1;
                        intr_id  <= win_id;
                    end
                end
                REQ: begin
                    if (intr_ack) begin
                        state    <= SERVICE;
                        intr_req <= 1'b0;
                    end else if (!mie) begin
                        state    <= IDLE;
                        intr_req <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (is_mret)
                        state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    intr_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intr_timer_ctrl.sv
// Directed testbench for intr_timer_ctrl with hand-computed expectations.
module tb_intr_timer_ctrl;

    localparam int NUM_IRQ = 8;
    localparam int TIMER_W = 32;
    localparam int PRESC_W = 8;
    localparam int ID_W    = $clog2(NUM_IRQ + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_IRQ-1:0] irq_in;
    logic               mie;
    logic               cfg_we;
    logic [2:0]         cfg_addr;
    logic [31:0]        cfg_wdata;
    logic [31:0]        cfg_rdata;
    logic               intr_ack;
    logic               is_mret;
    logic               intr_req;
    logic [ID_W-1:0]    intr_id;
    logic               t_intr;
    logic               e_intr;
    logic [TIMER_W-1:0] mtime;
`ifdef INTR_VECTOR_EN
    logic [31:0]        intr_pc;
`endif

    int tests  = 0;
    int failed = 0;

    intr_timer_ctrl #(
        .NUM_IRQ(NUM_IRQ), .TIMER_W(TIMER_W), .PRESC_W(PRESC_W), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .mie(mie),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .intr_ack(intr_ack), .is_mret(is_mret), .intr_req(intr_req), .intr_id(intr_id),
        .t_intr(t_intr), .e_intr(e_intr), .mtime(mtime)
`ifdef INTR_VECTOR_EN
        , .intr_pc(intr_pc)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [2:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        step(1);
        cfg_we = 1'b0; cfg_wdata = '0;
    endtask

    task automatic cfg_rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
        cfg_addr = a;
        #1;
        chk(tag, cfg_rdata, exp);
    endtask

    task automatic pulse_ack();
        intr_ack = 1'b1; step(1); intr_ack = 1'b0;
    endtask

    task automatic pulse_mret();
        is_mret = 1'b1; step(1); is_mret = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq_in = '0; mie = 1'b0; cfg_we = 1'b0; cfg_addr = '0;
        cfg_wdata = '0; intr_ack = 1'b0; is_mret = 1'b0;
        step(1);
        chk("rst_req", 32'(intr_req), 0);
        chk("rst_id", 32'(intr_id), 0);
        chk("rst_t", 32'(t_intr), 0);
        chk("rst_e", 32'(e_intr), 0);
        chk("rst_mtime", mtime, 0);
        cfg_rd("rst_cmp", 3'd2, 32'hFFFF_FFFF);
        cfg_rd("rst_en", 3'd0, 0);
        step(1);
        rst = 1'b0;

        // Timer: prescale 1, compare 10
        cfg_wr(3'd3, 1);
        cfg_wr(3'd2, 10);
        cfg_wr(3'd4, 0);
        chk("tm_start", mtime, 0);
        mie = 1'b1;
        step(19);
        chk("tm_9", mtime, 9);
        chk("tm_t9", 32'(t_intr), 0);
        step(1);
        chk("tm_10", mtime, 10);
        chk("tm_t10", 32'(t_intr), 1);
        chk("tm_req_lat", 32'(intr_req), 0);
        step(1);
        chk("tm_req", 32'(intr_req), 1);
        chk("tm_id", 32'(intr_id), 0);
        pulse_ack();
        chk("tm_svc_req", 32'(intr_req), 0);
        cfg_wr(3'd2, 100);
        chk("tm_t_clr", 32'(t_intr), 0);
        cfg_rd("tm_cmp_rd", 3'd2, 100);
        pulse_mret();
        step(3);
        chk("tm_no_req", 32'(intr_req), 0);

        // Edge external on irq_in[2]
        cfg_wr(3'd2, 32'hFFFF_FFFF);
        cfg_wr(3'd1, 32'h4);
        cfg_wr(3'd0, 32'h4);
        irq_in = 8'h04; step(1); irq_in = '0;
        chk("ed_e1", 32'(e_intr), 0);
        step(1);
        chk("ed_e2", 32'(e_intr), 0);
        step(1);
        chk("ed_e3", 32'(e_intr), 1);
        chk("ed_req_lat", 32'(intr_req), 0);
        step(1);
        chk("ed_req", 32'(intr_req), 1);
        chk("ed_id", 32'(intr_id), 3);
        pulse_ack();
        chk("ed_ack_clr", 32'(e_intr), 0);
        chk("ed_svc_id", 32'(intr_id), 3);
        irq_in = 8'h04; step(1); irq_in = '0;
        step(2);
        chk("ed_repend", 32'(e_intr), 1);
        step(2);
        chk("ed_svc_noreq", 32'(intr_req), 0);
        pulse_mret();
        chk("ed_mret_gap", 32'(intr_req), 0);
        step(1);
        chk("ed_req2", 32'(intr_req), 1);
        chk("ed_id2", 32'(intr_id), 3);
        pulse_ack();
        pulse_mret();
        step(1);
        chk("ed_idle", 32'(intr_req), 0);
        chk("ed_e_off", 32'(e_intr), 0);

        // Priority: timer + irq0 + irq5 (level)
        cfg_wr(3'd1, 0);
        cfg_wr(3'd0, 32'h21);
        mie = 1'b0;
        irq_in = 8'h21;
        cfg_wr(3'd2, 0);
        step(2);
        chk("pr_t", 32'(t_intr), 1);
        chk("pr_e", 32'(e_intr), 1);
        chk("pr_mie0", 32'(intr_req), 0);
        mie = 1'b1;
        step(1);
        chk("pr_req", 32'(intr_req), 1);
        chk("pr_id0", 32'(intr_id), 0);
        pulse_ack();
        cfg_wr(3'd2, 32'hFFFF_FFFF);
        chk("pr_t_clr", 32'(t_intr), 0);
        pulse_mret();
        step(1);
        chk("pr_req2", 32'(intr_req), 1);
        chk("pr_id1", 32'(intr_id), 1);
        pulse_ack();
        chk("pr_lvl_ack", 32'(e_intr), 1);
        chk("pr_svc_id", 32'(intr_id), 1);
        irq_in = '0;
        step(3);
        chk("pr_lvl_off", 32'(e_intr), 0);
        pulse_mret();
        step(2);
        chk("pr_idle", 32'(intr_req), 0);

        // Withdraw with ID 4 (irq_in[3], level)
        cfg_wr(3'd0, 32'h8);
        irq_in = 8'h08;
        step(2);
        chk("wd_e", 32'(e_intr), 1);
        step(1);
        chk("wd_req", 32'(intr_req), 1);
        chk("wd_id", 32'(intr_id), 4);
        mie = 1'b0;
        step(1);
        chk("wd_drop", 32'(intr_req), 0);
        step(2);
        chk("wd_idle", 32'(intr_req), 0);
        mie = 1'b1;
        step(1);
        chk("wd_req2", 32'(intr_req), 1);
        intr_ack = 1'b1; mie = 1'b0;
        step(1);
        intr_ack = 1'b0; mie = 1'b1;
        chk("wd_ackwin", 32'(intr_req), 0);
        step(2);
        chk("wd_in_svc", 32'(intr_req), 0);
        chk("wd_svc_id", 32'(intr_id), 4);
        irq_in = '0;
        step(3);
        pulse_mret();
        step(2);
        chk("wd_end", 32'(intr_req), 0);

        // Timer wrap and write priority
        mie = 1'b0;
        cfg_wr(3'd3, 0);
        cfg_wr(3'd4, 32'hFFFF_FFFF);
        chk("wr_max", mtime, 32'hFFFF_FFFF);
        chk("wr_t_eq", 32'(t_intr), 1);
        step(1);
        chk("wr_wrap", mtime, 0);
        chk("wr_t_low", 32'(t_intr), 0);
        cfg_wr(3'd4, 32'h55);
        chk("wr_prio", mtime, 32'h55);
        step(1);
        chk("wr_inc", mtime, 32'h56);

        // Config width masking and unused addresses
        cfg_wr(3'd0, 32'hFFFF_FFFF);
        cfg_rd("cf_en_mask", 3'd0, 32'hFF);
        cfg_wr(3'd3, 32'h1FF);
        cfg_rd("cf_ps_mask", 3'd3, 32'hFF);
        cfg_wr(3'd6, 32'h1234);
        cfg_rd("cf_unused", 3'd6, 0);
`ifndef INTR_VECTOR_EN
        cfg_wr(3'd5, 32'h100);
        cfg_rd("cf_no_vec", 3'd5, 0);
`endif
        cfg_wr(3'd0, 0);
        cfg_wr(3'd3, 0);

        // Request on ID 3, then async reset while in service
        mie = 1'b1;
        cfg_wr(3'd1, 32'h4);
        cfg_wr(3'd0, 32'h4);
`ifdef INTR_VECTOR_EN
        cfg_wr(3'd5, 32'h103);
        cfg_rd("vec_base", 3'd5, 32'h100);
`endif
        irq_in = 8'h04; step(1); irq_in = '0;
        step(3);
        chk("rs_req", 32'(intr_req), 1);
        chk("rs_id", 32'(intr_id), 3);
`ifdef INTR_VECTOR_EN
        chk("vec_pc", intr_pc, 32'h10C);
`endif
        pulse_ack();
        cfg_addr = 3'd0;
        #2 rst = 1'b1;
        #1;
        chk("rs_req0", 32'(intr_req), 0);
        chk("rs_id0", 32'(intr_id), 0);
        chk("rs_mtime0", mtime, 0);
        chk("rs_t0", 32'(t_intr), 0);
        chk("rs_e0", 32'(e_intr), 0);
        chk("rs_rdata0", cfg_rdata, 0);
`ifdef INTR_VECTOR_EN
        chk("rs_pc0", intr_pc, 0);
`endif
        step(1);
        rst = 1'b0;
        cfg_rd("rs_cmp", 3'd2, 32'hFFFF_FFFF);
        cfg_rd("rs_edge", 3'd1, 0);
        step(3);
        chk("rs_idle", 32'(intr_req), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
